// File: rtl/serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial front end for the Mealy sequence detectors. It accepts
// WIDTH-bit words on a valid/ready handshake and emits them one bit per clock
// on sout, qualified by bit_valid. A one-word holding register lets
// back-to-back words stream with no idle bit between frames.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   load_data   word to serialise
//   load_valid  load_data is valid
//   load_ready  a word can be accepted this cycle (combinational, from flops)
//   sout        serial bit, forced to 0 whenever bit_valid is low
//   bit_valid   sout carries a real data bit this cycle
//   frame_done  high during the last bit of each word
//   busy        shifting in progress or a word is held
// ---------------------------------------------------------------------------
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             bit_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sreg_shifted;

  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & load_ready & reset;
  assign last_bit   = (cnt_q == CNT_LAST);

  // Move the next bit into the head position.
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q + CW'(1);
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // load_ready is low here, so no new word can collide with the transfer.
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          // Word arriving on the last-bit edge bypasses hold.
          sreg_d = load_data;
          cnt_d  = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered: compute what the next cycle should present.
    bit_valid_d  = (state_d == SHIFT);
    sout_d       = bit_valid_d & (MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0]);
    frame_done_d = bit_valid_d & (cnt_d == CNT_LAST);
    busy_d       = bit_valid_d | hold_full_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    if (!reset) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign bit_valid  = bit_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Two instances (MSB-first and LSB-first) share one stimulus stream. Every
// accepted word pushes its bits, in send order, onto a per-instance
// scoreboard; each cycle the oldest entry is popped and compared against
// sout/frame_done. The number of bits still owed predicts bit_valid, busy and
// load_ready: anything owed means busy, and more than one word owed means
// hold is full. A small 1001 Mealy detector model watches the MSB-first
// stream for the integration case.
// ---------------------------------------------------------------------------
module tb_serial_bit_feeder;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } sb_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] load_data;
  logic         load_valid;

  logic ready_w [2];
  logic sout_w  [2];
  logic bv_w    [2];
  logic fd_w    [2];
  logic busy_w  [2];

  sb_t sb [2][$];

  int n_checks = 0;
  int n_errors = 0;

  // Integration detector model (1001, overlapping) on the MSB-first stream.
  logic       det_on;
  logic [2:0] det_hist;
  int         det_cnt;
  logic [7:0] det_mask;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (ready_w[0]),
    .sout       (sout_w[0]),
    .bit_valid  (bv_w[0]),
    .frame_done (fd_w[0]),
    .busy       (busy_w[0])
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (ready_w[1]),
    .sout       (sout_w[1]),
    .bit_valid  (bv_w[1]),
    .frame_done (fd_w[1]),
    .busy       (busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor and scoreboard: outputs are sampled on the falling edge, well
  // away from the rising edge where the DUT updates.
  always @(negedge clk) begin : monitor
    int  n;
    sb_t e;
    for (int d = 0; d < 2; d++) begin
      n = sb[d].size();
      check($sformatf("bit_valid[%0d]", d), 32'(bv_w[d]),    32'(n > 0));
      check($sformatf("busy[%0d]", d),      32'(busy_w[d]),  32'(n > 0));
      check($sformatf("load_ready[%0d]", d),32'(ready_w[d]), 32'(n <= W));
      if (n > 0) begin
        e = sb[d].pop_front();
        check($sformatf("sout[%0d]", d),       32'(sout_w[d]), 32'(e.b));
        check($sformatf("frame_done[%0d]", d), 32'(fd_w[d]),   32'(e.last));
      end else begin
        check($sformatf("sout_idle[%0d]", d),  32'(sout_w[d]), 32'd0);
        check($sformatf("fd_idle[%0d]", d),    32'(fd_w[d]),   32'd0);
      end
    end

    if (det_on && bv_w[0]) begin
      if (det_cnt >= 3 && {det_hist, sout_w[0]} == 4'b1001 && det_cnt < 8)
        det_mask[det_cnt] = 1'b1;
      det_hist = {det_hist[1:0], sout_w[0]};
      det_cnt++;
    end

    // Predict what the coming rising edge will do.
    if (!reset) begin
      sb[0].delete();
      sb[1].delete();
    end else if (load_valid && ready_w[0]) begin
      for (int i = 0; i < W; i++) begin
        sb[0].push_back('{b: load_data[W-1-i], last: (i == W-1)});
        sb[1].push_back('{b: load_data[i],     last: (i == W-1)});
      end
    end
  end

  // Present a word and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] w);
    load_data  = w;
    load_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_w[0]) begin
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'd1, 32'd0);
    load_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sb[0].size() == 0 && sb[1].size() == 0) return;
    end
    check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    det_on   = 1'b0;
    det_hist = '0;
    det_cnt  = 0;
    det_mask = '0;

    // Reset held with a valid word offered: nothing may be accepted.
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    load_valid = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single word, then idle.
    send(8'b1001_1001);
    drain();
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back words: second lands in hold, stream stays contiguous.
    send(8'hA5);
    send(8'h3C);
    drain();
    repeat (2) @(posedge clk);
    #1;

    // LSB-first instance sees 1 then seven 0s.
    send(8'h01);
    drain();

    // Zero sent twice is still 16 valid bits.
    send(8'h00);
    send(8'h00);
    drain();

    // Reset in the middle of a frame after 3 bits.
    send(8'hF0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_bv", 32'(bv_w[0]), 32'd0);
    check("post_reset_ready", 32'(ready_w[0]), 32'd1);
    send(8'h81);
    drain();

    // Three words with load_valid held across accepts.
    send(8'h5A);
    send(8'hC3);
    send(8'h7E);
    drain();

    // Integration with the 1001 detector: hits on bits 4 and 7 (1-based).
    det_hist = '0;
    det_cnt  = 0;
    det_mask = '0;
    det_on   = 1'b1;
    send(8'b1001_0010);
    drain();
    det_on = 1'b0;
    check("det_mask", 32'(det_mask), 32'h48);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_msb", 32'(sb[0].size()), 32'd0);
    check("sb_empty_lsb", 32'(sb[1].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
